hazard_stall_controller: RTL

- Parametrised successor to the pipeline's single-cycle load-use hazard detector.
- Sits in the ID stage and drives PC hold, IF/ID hold/flush and the ID/EX control-bubble mux.
- Adds configurable multi-cycle load-use stalls for slower data memory, register-0 exclusion and per-operand use qualification.
- Adds a data-memory-busy pipeline freeze, taken-branch flush and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_stall_controller_if.sv | 43 ++++
 rtl/hazard_compare.sv | 30 +++
 rtl/hazard_stall_controller.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard/stall logic: FSM states,
// default register-specifier width and the legal load-use stall range.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W      = 5;
    localparam int LOAD_USE_STALLS_MIN = 1;
    localparam int LOAD_USE_STALLS_MAX = 7;
    localparam int STALL_CNT_W         = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stallState_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ID-stage hazard bus: register specifiers and pipeline status in from the
// datapath, hold/flush/bubble controls and stall statistics back out.
interface hazard_stall_controller_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 16
);

    logic [REG_ADDR_W-1:0] IFIDRegrs;
    logic [REG_ADDR_W-1:0] IFIDRegrt;
    logic                  IFIDUseRs;
    logic                  IFIDUseRt;
    logic [REG_ADDR_W-1:0] IDEXRegrt;
    logic                  memRead;
    logic                  branchTaken;
    logic                  memBusy;

    logic                  controlMUX;
    logic                  IFIDRegHOLD;
    logic                  pcHOLD;
    logic                  IFIDFlush;
    logic                  IDEXHOLD;
    logic                  stallBusy;
    logic [CNT_W-1:0]      stallCount;

    // Pipeline datapath side.
    modport master (
        output IFIDRegrs, IFIDRegrt, IFIDUseRs, IFIDUseRt,
        output IDEXRegrt, memRead, branchTaken, memBusy,
        input  controlMUX, IFIDRegHOLD, pcHOLD, IFIDFlush,
        input  IDEXHOLD, stallBusy, stallCount
    );

    // Hazard controller side.
    modport slave (
        input  IFIDRegrs, IFIDRegrt, IFIDUseRs, IFIDUseRt,
        input  IDEXRegrt, memRead, branchTaken, memBusy,
        output controlMUX, IFIDRegHOLD, pcHOLD, IFIDFlush,
        output IDEXHOLD, stallBusy, stallCount
    );

endinterface

// File: rtl/hazard_compare.sv
// Register-match logic: does a valid destination in a later stage collide with
// a source operand the ID instruction actually reads? Register 0 never matches
// because it is hardwired to zero. Shared with the forwarding unit.
module hazard_compare
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] srcRs,
    input  logic [REG_ADDR_W-1:0] srcRt,
    input  logic                  useRs,
    input  logic                  useRt,
    input  logic [REG_ADDR_W-1:0] dstReg,
    input  logic                  dstValid,
    output logic                  match
);

    logic dstNonZero;
    logic rsHit;
    logic rtHit;

    // Per-operand qualification; an rs+rt double hit still yields one match.
    always_comb begin
        dstNonZero = (dstReg != '0);
        rsHit      = useRs && (dstReg == srcRs);
        rtHit      = useRt && (dstReg == srcRt);
        match      = dstValid && dstNonZero && (rsHit || rtHit);
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage load-use hazard controller. Inserts LOAD_USE_STALLS bubbles per
// load-use hazard, freezes the whole pipeline while data memory is busy and
// flushes IF/ID on a taken branch. Outputs are combinational so a hazard
// stalls in the very cycle it is seen; a saturating counter tallies bubbles.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
    parameter int LOAD_USE_STALLS = 1,
    parameter int CNT_W           = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  hazIf
);

    // Elaboration-time guard: the 3-bit down-counter only covers 1..7 bubbles.
    generate
        if (LOAD_USE_STALLS < LOAD_USE_STALLS_MIN ||
            LOAD_USE_STALLS > LOAD_USE_STALLS_MAX) begin : gBadStallCount
            $error("hazard_stall_controller: LOAD_USE_STALLS out of range 1..7");
        end
    endgenerate

    localparam bit                   MULTI_STALL = (LOAD_USE_STALLS > 1);
    localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_USE_STALLS - 1);

    stallState_e            stateQ;
    stallState_e            stateD;
    logic [STALL_CNT_W-1:0] cntQ;
    logic [STALL_CNT_W-1:0] cntD;
    logic [CNT_W-1:0]       stallCountQ;
    logic [CNT_W-1:0]       stallCountD;
    logic                   bubbleInserted;
    logic                   hazard;

    logic ctrlMuxRaw;
    logic ifidHoldRaw;
    logic pcHoldRaw;
    logic ifidFlushRaw;
    logic idexHoldRaw;

    // Saturating +1 for the performance counter; it must never wrap.
    function automatic logic [CNT_W-1:0] satIncrement(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end
        return value + CNT_W'(1);
    endfunction

    hazard_compare #(
        .REG_ADDR_W (REG_ADDR_W)
    ) uCompare (
        .srcRs    (hazIf.IFIDRegrs),
        .srcRt    (hazIf.IFIDRegrt),
        .useRs    (hazIf.IFIDUseRs),
        .useRt    (hazIf.IFIDUseRt),
        .dstReg   (hazIf.IDEXRegrt),
        .dstValid (hazIf.memRead),
        .match    (hazard)
    );

    // Next-state and control decode; memBusy beats branchTaken beats stalling.
    always_comb begin
        stateD         = stateQ;
        cntD           = cntQ;
        bubbleInserted = 1'b0;
        ctrlMuxRaw     = 1'b0;
        ifidHoldRaw    = 1'b0;
        pcHoldRaw      = 1'b0;
        ifidFlushRaw   = 1'b0;
        idexHoldRaw    = 1'b0;

        if (hazIf.memBusy) begin
            // Whole pipeline frozen; EX contents re-present next cycle.
            pcHoldRaw   = 1'b1;
            ifidHoldRaw = 1'b1;
            idexHoldRaw = 1'b1;
        end else if (hazIf.branchTaken) begin
            // ID instruction is wrong-path, so any pending stall is moot.
            ifidFlushRaw = 1'b1;
            ctrlMuxRaw   = 1'b1;
            stateD       = IDLE;
            cntD         = '0;
        end else begin
            unique case (stateQ)
                IDLE: begin
                    if (hazard) begin
                        ctrlMuxRaw     = 1'b1;
                        ifidHoldRaw    = 1'b1;
                        pcHoldRaw      = 1'b1;
                        bubbleInserted = 1'b1;
                        if (MULTI_STALL) begin
                            stateD = STALL;
                            cntD   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    // The load has moved on; keep bubbling until cnt runs out.
                    ctrlMuxRaw     = 1'b1;
                    ifidHoldRaw    = 1'b1;
                    pcHoldRaw      = 1'b1;
                    bubbleInserted = 1'b1;
                    cntD           = cntQ - STALL_CNT_W'(1);
                    if (cntQ == STALL_CNT_W'(1)) begin
                        stateD = IDLE;
                    end
                end
                default: begin
                    stateD = IDLE;
                    cntD   = '0;
                end
            endcase
        end

        stallCountD = bubbleInserted ? satIncrement(stallCountQ) : stallCountQ;
    end

    // State, bubble down-counter and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= IDLE;
            cntQ        <= '0;
            stallCountQ <= '0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= cntD;
            stallCountQ <= stallCountD;
        end
    end

    // Outputs forced low while reset is asserted, even if a hazard is present.
    always_comb begin
        hazIf.controlMUX  = rst_n && ctrlMuxRaw;
        hazIf.IFIDRegHOLD = rst_n && ifidHoldRaw;
        hazIf.pcHOLD      = rst_n && pcHoldRaw;
        hazIf.IFIDFlush   = rst_n && ifidFlushRaw;
        hazIf.IDEXHOLD    = rst_n && idexHoldRaw;
        hazIf.stallBusy   = rst_n && (stateQ == STALL);
        hazIf.stallCount  = rst_n ? stallCountQ : '0;
    end

endmodule
